// File: rtl/mmio_map_pkg.sv
// Memory map for the core data-port bus controller.
// Base/mask/wait tables plus controller state encoding.
package mmio_map_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP,
    ERR
  } state_t;

  localparam int N_SLAVES_DEF = 4;

  localparam int SLV_ROM  = 0;
  localparam int SLV_RAM  = 1;
  localparam int SLV_GPIO = 2;
  localparam int SLV_UART = 3;

  localparam logic [31:0] SLV_BASE [N_SLAVES_DEF] = '{
    32'h0040_0000,
    32'h1001_0000,
    32'h1001_0020,
    32'h1001_0030
  };

  localparam logic [31:0] SLV_MASK [N_SLAVES_DEF] = '{
    32'hFFC0_0000,
    32'hFFFF_FFE0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0
  };

  localparam int SLV_WAIT [N_SLAVES_DEF] = '{1, 0, 0, 2};

endpackage

// File: rtl/mmio_bus_ctrl_addr_decoder.sv
// Address decoder: base/mask match per region,
// lowest index wins, one-hot winner plus index.
module mmio_addr_decoder
  import mmio_map_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLAVES   = 4,
  parameter int IDX_W      = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [N_SLAVES-1:0]   hit,
  output logic [IDX_W-1:0]      idx,
  output logic                  miss
);

  logic [N_SLAVES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      match[i] = (addr & ADDR_WIDTH'(SLV_MASK[i]))
                 == ADDR_WIDTH'(SLV_BASE[i]);
    end
  end

  // Scan high to low so the lowest matching index is the last write.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

  assign miss = ~|match;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Core data-port to memory-mapped slave bus controller.
// One slave at a time, per-slave wait states, error on unmapped.
module mmio_bus_ctrl
  import mmio_map_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLAVES   = 4,
  parameter int WAIT_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         ready,
  output logic                         err,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic                         s_we,
  output logic [ADDR_WIDTH-1:0]        s_addr,
  output logic [DATA_WIDTH-1:0]        s_wdata,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  state_t              state;
  state_t              nstate;
  logic [N_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                miss;
  logic [WAIT_W-1:0]   wait_lu;
  logic [N_SLAVES-1:0] sel_q;
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic [WAIT_W-1:0]   cnt;
  logic                accept;

  mmio_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SLAVES   (N_SLAVES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .addr (addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (miss)
  );

  assign wait_lu = WAIT_W'(SLV_WAIT[dec_idx]);
  assign accept  = (state == IDLE) && req;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (miss)
            nstate = ERR;
          else if (wait_lu == '0)
            nstate = ACCESS;
          else
            nstate = WAIT;
        end
      end
      WAIT:    if (cnt == WAIT_W'(1)) nstate = ACCESS;
      ACCESS:  nstate = RESP;
      RESP:    nstate = IDLE;
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      cnt     <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      rdata   <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        s_addr  <= addr;
        s_wdata <= wdata;
        we_q    <= we;
        idx_q   <= dec_idx;
        sel_q   <= dec_hit;
        cnt     <= wait_lu;
        // Clear here so rdata already reads 0 during the ERR response.
        if (miss) rdata <= '0;
      end
      if (state == WAIT)
        cnt <= cnt - WAIT_W'(1);
      if (state == ACCESS && !we_q)
        rdata <= s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign busy  = (state != IDLE);
  assign ready = (state == RESP) || (state == ERR);
  assign err   = (state == ERR);
  assign s_sel = (state == WAIT || state == ACCESS) ? sel_q : '0;
  assign s_we  = (state == ACCESS) && we_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: reset, per-slave
// reads/writes, wait states, unmapped error, back-to-back.
module tb_mmio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         ready;
  logic         err;
  logic         busy;
  logic [31:0]  rdata;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .err     (err),
    .busy    (busy),
    .rdata   (rdata),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata)
  );

  task automatic start(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    s_rdata = '0;
    s_rdata[0 +: 32]  = 32'hC0DE_0000;
    s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    s_rdata[64 +: 32] = 32'h2222_2222;
    s_rdata[96 +: 32] = 32'h0000_0041;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ready, err, busy, s_sel, s_we} !== 8'h00)
      $display("FAIL reset_ctl got %b want 0",
               {ready, err, busy, s_sel, s_we});
    else n_pass++;
    n_total++;
    if ({rdata, s_addr, s_wdata} !== 96'h0)
      $display("FAIL reset_data got %h want 0",
               {rdata, s_addr, s_wdata});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_read();
    start(1'b0, 32'h1001_0004, 32'h0);
    @(negedge clk);
    n_total++;
    if (s_sel !== 4'b0010 || s_we !== 1'b0 || ready !== 1'b0)
      $display("FAIL ram_access sel=%b we=%b rdy=%b want 0010/0/0",
               s_sel, s_we, ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF)
      $display("FAIL ram_resp rdy=%b err=%b rdata=%h want 1/0/deadbeef",
               ready, err, rdata);
    else n_pass++;
    req = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'hDEAD_BEEF)
      $display("FAIL ram_idle busy=%b rdy=%b rdata=%h want 0/0/deadbeef",
               busy, ready, rdata);
    else n_pass++;
  endtask

  task automatic test_gpio_write();
    int we_cyc = 0;
    int bad_we = 0;
    int rdy_at = -1;
    start(1'b1, 32'h1001_0024, 32'h0000_00A5);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (s_we) begin
        we_cyc++;
        if (s_sel !== 4'b0100 || s_wdata !== 32'hA5) bad_we++;
      end
      if (ready) begin
        rdy_at = k;
        break;
      end
    end
    req = 1'b0;
    n_total++;
    if (rdy_at != 2)
      $display("FAIL gpio_latency got %0d want 2", rdy_at);
    else n_pass++;
    n_total++;
    if (we_cyc != 1 || bad_we != 0)
      $display("FAIL gpio_we cycles=%0d bad=%0d want 1/0",
               we_cyc, bad_we);
    else n_pass++;
    n_total++;
    if (rdata !== 32'hDEAD_BEEF || err !== 1'b0)
      $display("FAIL gpio_rdata rdata=%h err=%b want deadbeef/0",
               rdata, err);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_uart_wait_read();
    int sel_cyc = 0;
    int rdy_at = -1;
    start(1'b0, 32'h1001_0030, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s_sel == 4'b1000) sel_cyc++;
      if (ready) begin
        rdy_at = k;
        break;
      end
    end
    req = 1'b0;
    n_total++;
    if (rdy_at != 4)
      $display("FAIL uart_latency got %0d want 4", rdy_at);
    else n_pass++;
    n_total++;
    if (sel_cyc != 3)
      $display("FAIL uart_sel_cycles got %0d want 3", sel_cyc);
    else n_pass++;
    n_total++;
    if (rdata !== 32'h0000_0041 || err !== 1'b0)
      $display("FAIL uart_rdata rdata=%h err=%b want 00000041/0",
               rdata, err);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    int act = 0;
    int rdy_at = -1;
    logic e = 1'b0;
    logic [31:0] rd = '1;
    start(1'b1, 32'h2000_0000, 32'hFFFF_FFFF);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (s_sel != 4'b0 || s_we) act++;
      if (ready) begin
        rdy_at = k;
        e = err;
        rd = rdata;
        break;
      end
    end
    req = 1'b0;
    n_total++;
    if (rdy_at != 1 || e !== 1'b1)
      $display("FAIL unmapped_resp at=%0d err=%b want 1/1", rdy_at, e);
    else n_pass++;
    n_total++;
    if (rd !== 32'h0 || act != 0)
      $display("FAIL unmapped_side rdata=%h slave_act=%0d want 0/0",
               rd, act);
    else n_pass++;
    @(negedge clk);
    if (s_sel != 4'b0 || s_we) act++;
    n_total++;
    if (act != 0 || busy !== 1'b0)
      $display("FAIL unmapped_after act=%0d busy=%b want 0/0", act, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    start(1'b0, 32'h0040_0008, 32'h0);
    @(negedge clk);
    addr = 32'h1001_0004;
    if (s_sel !== 4'b0001 || s_addr !== 32'h0040_0008) bad++;
    @(negedge clk);
    addr = 32'h2000_0000;
    if (s_sel !== 4'b0001 || s_addr !== 32'h0040_0008 || ready) bad++;
    @(negedge clk);
    n_total++;
    if (bad != 0)
      $display("FAIL b2b_latched bad_cycles=%0d want 0", bad);
    else n_pass++;
    n_total++;
    if (ready !== 1'b1 || rdata !== 32'hC0DE_0000 || err !== 1'b0)
      $display("FAIL b2b_rom rdy=%b rdata=%h err=%b want 1/c0de0000/0",
               ready, rdata, err);
    else n_pass++;
    addr = 32'h1001_0024;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || ready !== 1'b0)
      $display("FAIL b2b_idle busy=%b rdy=%b want 0/0", busy, ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (s_sel !== 4'b0100 || s_addr !== 32'h1001_0024)
      $display("FAIL b2b_second sel=%b s_addr=%h want 0100/10010024",
               s_sel, s_addr);
    else n_pass++;
    @(negedge clk);
    req = 1'b0;
    n_total++;
    if (ready !== 1'b1 || rdata !== 32'h2222_2222)
      $display("FAIL b2b_second_resp rdy=%b rdata=%h want 1/22222222",
               ready, rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int we_seen = 0;
    int rdy_at = -1;
    start(1'b1, 32'h1001_0034, 32'h0000_0055);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || s_sel !== 4'b1000 || s_we !== 1'b0)
      $display("FAIL rmw_wait busy=%b sel=%b we=%b want 1/1000/0",
               busy, s_sel, s_we);
    else n_pass++;
    rst = 1'b0;
    req = 1'b0;
    #1;
    n_total++;
    if ({ready, err, busy, s_sel, s_we} !== 8'h00 ||
        {rdata, s_addr, s_wdata} !== 96'h0)
      $display("FAIL rmw_async ctl=%b data=%h want 0/0",
               {ready, err, busy, s_sel, s_we},
               {rdata, s_addr, s_wdata});
    else n_pass++;
    @(negedge clk);
    if (s_we) we_seen++;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (s_we || ready) we_seen++;
    end
    n_total++;
    if (we_seen != 0)
      $display("FAIL rmw_abort stray_cycles=%0d want 0", we_seen);
    else n_pass++;
    start(1'b0, 32'h1001_0004, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready) begin
        rdy_at = k;
        break;
      end
    end
    req = 1'b0;
    n_total++;
    if (rdy_at != 2 || rdata !== 32'hDEAD_BEEF)
      $display("FAIL rmw_next at=%0d rdata=%h want 2/deadbeef",
               rdy_at, rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_gpio_write();
    test_uart_wait_read();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
Parametrised memory-map bus controller between the core's data port and N memory-mapped slaves (ROM, RAM, GPIO, UART, ...).
- Decodes each request against a base/mask table from a package.
- Drives one slave at a time, inserting a per-slave number of wait states.
- Returns registered read data with a ready/err handshake to the core.
- Flags unmapped addresses as errors instead of aliasing them.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
N_SLAVES, 4, number of decoded regions (must match package tables)
WAIT_W, 3, width of the wait-state counter (max 2^WAIT_W-1 wait cycles)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  1  core access request, held high until ready
we  in  1  1=write, 0=read (sampled with req)
addr  in  ADDR_WIDTH  byte address
wdata  in  DATA_WIDTH  write data
ready  out  1  one-cycle completion pulse
err  out  1  with ready: access was unmapped
busy  out  1  transaction in progress (state != IDLE)
rdata  out  DATA_WIDTH  registered read data, valid when ready=1 and we was 0
s_sel  out  N_SLAVES  one-hot slave select
s_we  out  1  slave write strobe
s_addr  out  ADDR_WIDTH  latched address to slaves
s_wdata  out  DATA_WIDTH  latched write data to slaves
s_rdata  in  N_SLAVES*DATA_WIDTH  packed slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - ready, err, busy, s_sel and s_we = 0.
  - rdata, s_addr, s_wdata and the wait counter = 0.
  - A reset mid-transaction aborts it: no write strobe, no ready.
- Decode (combinational, IDLE only):
  - hit[i] = ((addr & MASK[i]) == BASE[i]).
  - Lowest index wins on overlap.
  - miss = no hit.
- FSM states: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE:
  - req=1 latches addr, we, wdata and the winning index.
  - miss -> ERR.
  - hit with WAIT_CYC[idx]==0 -> ACCESS.
  - hit otherwise -> WAIT, with counter loaded to WAIT_CYC[idx].
  - req=0 -> stay in IDLE.
- WAIT:
  - s_sel[idx]=1, s_we=0.
  - Counter decrements each cycle; when counter==1 -> ACCESS.
- ACCESS: exactly one cycle.
  - s_sel[idx]=1, s_we=latched we.
  - rdata <= slave idx read data when read; rdata is unchanged on writes.
  - -> RESP.
- RESP:
  - ready=1, err=0, s_sel=0.
  - -> IDLE.
- ERR:
  - ready=1, err=1, rdata <= 0, no slave selected, s_we never asserted.
  - -> IDLE.
- Latency: req sampled at cycle 0, ready at cycle 2+WAIT_CYC[idx]; unmapped access ready at cycle 1.
- Throughput: a new req is accepted in the IDLE cycle following RESP/ERR. req and addr changes while busy are ignored.
- s_we is asserted at most one cycle per write transaction and only in ACCESS.
- s_addr and s_wdata hold the latched values from acceptance until the next acceptance.
- busy=1 in WAIT, ACCESS, RESP and ERR.
- rdata holds its value between transactions.

Decomposition:
- Package mmio_map_pkg:
  - state_t enum (IDLE, WAIT, ACCESS, RESP, ERR).
  - N_SLAVES_DEF, and the SLV_BASE, SLV_MASK and SLV_WAIT constant arrays. Default map:
    - 0: ROM 0x00400000 / 0xFFC00000 / 1 wait.
    - 1: RAM 0x10010000 / 0xFFFFFFE0 / 0 wait.
    - 2: GPIO 0x10010020 / 0xFFFFFFF0 / 0 wait.
    - 3: UART 0x10010030 / 0xFFFFFFF0 / 2 wait.
  - Slave index constants (SLV_ROM, SLV_RAM, SLV_GPIO, SLV_UART).
- Sub-module mmio_addr_decoder: combinational; addr in, one-hot hit, priority-encoded index and miss out.

Test Plan:
- Reset mid-WAIT: start a UART write to 0x10010034, then pulse rst=0 in the first WAIT cycle -> all outputs 0, s_we never high, next req accepted normally.
- RAM read: addr=0x10010004, slave1 returns 0xDEADBEEF -> s_sel=4'b0010 in ACCESS, ready at cycle 2 with rdata=0xDEADBEEF, err=0.
- GPIO write: addr=0x10010024, wdata=0x000000A5 -> s_we high exactly one cycle with s_sel=4'b0100 and s_wdata=0xA5; ready at cycle 2; rdata unchanged.
- UART read with waits: addr=0x10010030, slave3=0x00000041 -> s_sel=4'b1000 for 3 cycles (2 WAIT + ACCESS); ready at cycle 4, rdata=0x41.
- Unmapped: addr=0x20000000 -> ready=1 and err=1 at cycle 1, rdata=0, s_sel=0 and s_we=0 throughout.
- Back-to-back plus busy masking: ROM read 0x00400008 with addr toggled while busy -> latched address used, ready at cycle 3; a second req held high is accepted in the following IDLE cycle.
